// File: rtl/tick_edge_sync.sv
// Single-clock step-tick generator with per-channel button edge capture, released on the next tick.
// Optional build macro DEBOUNCE_EN adds a per-channel stability filter ahead of edge detection.
module tick_edge_sync #(
    parameter int DIV       = 50_000_000,
    parameter int CH        = 1,
    parameter int EDGE_FALL = 1,
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic          clk_50M,
    input  logic          rst,
    input  logic [CH-1:0] btn_in,
    output logic          tick,
    output logic          clk_slow,
    output logic [CH-1:0] pulse_out,
    output logic [CH-1:0] pending
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIV / 2);
    // Level the button rests at; flops start here so reset release is edge-free.
    localparam logic IDLE_LVL = (EDGE_FALL != 0);

    if (DIV < 2 || CH < 1 || DB_CYCLES < 1) begin : g_param_check
        $error("tick_edge_sync: DIV must be >= 2, CH >= 1, DB_CYCLES >= 1");
    end

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             tick_reg;
    logic             clk_slow_reg;

    assign cnt_next = (cnt_reg == CNT_MAX) ? '0 : cnt_reg + CNT_W'(1);

    always_ff @(posedge clk_50M) begin
        if (rst) begin
            cnt_reg      <= '0;
            tick_reg     <= 1'b0;
            clk_slow_reg <= 1'b0;
        end else begin
            cnt_reg      <= cnt_next;
            tick_reg     <= (cnt_reg == CNT_MAX);
            clk_slow_reg <= (cnt_next >= CNT_HALF);
        end
    end

    assign tick     = tick_reg;
    assign clk_slow = clk_slow_reg;

    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_ch
            logic meta_reg;
            logic sync_reg;
            logic det_level;
            logic det_d_reg;
            logic edge_reg;
            logic edge_next;
            logic pending_reg;
            logic pulse_reg;

`ifdef DEBOUNCE_EN
            localparam int DB_W = $clog2(DB_CYCLES + 1);
            localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

            logic [DB_W-1:0] db_cnt_reg;
            logic            st_reg;

            // st follows the synchronised level only after DB_CYCLES consecutive disagreeing cycles.
            always_ff @(posedge clk_50M) begin
                if (rst) begin
                    db_cnt_reg <= '0;
                    st_reg     <= IDLE_LVL;
                end else if (sync_reg == st_reg) begin
                    db_cnt_reg <= '0;
                end else if (db_cnt_reg == DB_LAST) begin
                    st_reg     <= sync_reg;
                    db_cnt_reg <= '0;
                end else begin
                    db_cnt_reg <= db_cnt_reg + DB_W'(1);
                end
            end

            assign det_level = st_reg;
`else
            assign det_level = sync_reg;
`endif

            assign edge_next = (EDGE_FALL != 0) ? (det_d_reg & ~det_level)
                                                : (det_level & ~det_d_reg);

            always_ff @(posedge clk_50M) begin
                if (rst) begin
                    meta_reg    <= IDLE_LVL;
                    sync_reg    <= IDLE_LVL;
                    det_d_reg   <= IDLE_LVL;
                    edge_reg    <= 1'b0;
                    pending_reg <= 1'b0;
                    pulse_reg   <= 1'b0;
                end else begin
                    meta_reg  <= btn_in[gi];
                    sync_reg  <= meta_reg;
                    det_d_reg <= det_level;
                    edge_reg  <= edge_next;
                    // An edge coinciding with the tick is released directly, never parked.
                    if (tick_reg) begin
                        pulse_reg   <= pending_reg | edge_reg;
                        pending_reg <= 1'b0;
                    end else begin
                        pulse_reg   <= 1'b0;
                        pending_reg <= pending_reg | edge_reg;
                    end
                end
            end

            assign pulse_out[gi] = pulse_reg;
            assign pending[gi]   = pending_reg;
        end
    endgenerate

endmodule

// File: tb/tb_tick_edge_sync.sv
// Scoreboard bench for tick_edge_sync: stimulus queues per-cycle expectations, a negedge monitor checks them.
module tb_tick_edge_sync;

    localparam int DIV = 8;

    logic       clk_50M = 1'b0;
    logic       rst     = 1'b1;
    logic [1:0] btn_in  = 2'b11;
    logic       tick;
    logic       clk_slow;
    logic [1:0] pulse_out;
    logic [1:0] pending;

    always #5 clk_50M = ~clk_50M;

    tick_edge_sync #(
        .DIV       (DIV),
        .CH        (2),
        .EDGE_FALL (1),
        .DB_CYCLES (4)
    ) dut (
        .clk_50M   (clk_50M),
        .rst       (rst),
        .btn_in    (btn_in),
        .tick      (tick),
        .clk_slow  (clk_slow),
        .pulse_out (pulse_out),
        .pending   (pending)
    );

    typedef struct {
        int         cyc;
        logic       tick;
        logic       slow;
        logic [1:0] pulse;
        logic [1:0] pend;
        string      tag;
    } exp_t;

    exp_t  sb_q[$];
    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;
    string cur_test = "init";

    task automatic check2(input string name, input int c, input logic [1:0] act, input logic [1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s cycle %0d: got %b, expected %b", name, c, act, req);
        end
    endtask

    // Apply rst/btn before the next edge and queue what the DUT must show in the following cycle.
    task automatic run_cycle(input logic r, input logic [1:0] b, input logic [1:0] ep, input logic [1:0] en);
        exp_t e;
        rst    = r;
        btn_in = b;
        @(posedge clk_50M);
        #1;
        if (r) cyc = 0;
        else   cyc++;
        e.cyc   = cyc;
        e.tick  = !r && (cyc % DIV == 0);
        e.slow  = !r && (cyc % DIV >= DIV / 2);
        e.pulse = r ? 2'b00 : ep;
        e.pend  = r ? 2'b00 : en;
        e.tag   = cur_test;
        sb_q.push_back(e);
    endtask

    always @(negedge clk_50M) begin
        exp_t m;
        if (sb_q.size() != 0) begin
            m = sb_q.pop_front();
            check2({m.tag, ".tick"},      m.cyc, {1'b0, tick},     {1'b0, m.tick});
            check2({m.tag, ".clk_slow"},  m.cyc, {1'b0, clk_slow}, {1'b0, m.slow});
            check2({m.tag, ".pulse_out"}, m.cyc, pulse_out,        m.pulse);
            check2({m.tag, ".pending"},   m.cyc, pending,          m.pend);
            if (pulse_out != 2'b00 || m.pulse != 2'b00)
                $display("%s cycle %0d pulse_out=%b pending=%b", m.tag, m.cyc, pulse_out, pending);
        end
    end

    task automatic do_reset();
        run_cycle(1'b1, 2'b11, 2'b00, 2'b00);
        run_cycle(1'b1, 2'b11, 2'b00, 2'b00);
    endtask

    initial begin
        logic [1:0] b, ep, en;

        // Free-running tick and square wave, buttons idle.
        cur_test = "idle";
        do_reset();
        for (int k = 1; k <= 32; k++) run_cycle(1'b0, 2'b11, 2'b00, 2'b00);

`ifndef DEBOUNCE_EN
        // ch0 falls before edge 10 -> pending 13..16, pulse 17; ch1 falls before edge 5 -> pending 8, pulse 9.
        cur_test = "single";
        do_reset();
        for (int k = 1; k <= 26; k++) begin
            b  = {(k >= 5) ? 1'b0 : 1'b1, (k >= 10) ? 1'b0 : 1'b1};
            ep = (k == 17) ? 2'b01 : (k == 9) ? 2'b10 : 2'b00;
            en = {k == 8, k >= 13 && k <= 16};
            run_cycle(1'b0, b, ep, en);
        end

        // Three falls on ch1 between ticks 8 and 16 collapse into one pulse at 17.
        cur_test = "multi";
        do_reset();
        for (int k = 1; k <= 26; k++) begin
            b  = {(k == 9 || k == 11 || k >= 13) ? 1'b0 : 1'b1, 1'b1};
            ep = {k == 17, 1'b0};
            en = {k >= 12 && k <= 16, 1'b0};
            run_cycle(1'b0, b, ep, en);
        end

        // Detected edge lands on the tick cycle 16: pulse at 17, pending never set.
        cur_test = "tick_edge";
        do_reset();
        for (int k = 1; k <= 26; k++) begin
            b  = {1'b1, (k >= 14) ? 1'b0 : 1'b1};
            ep = {1'b0, k == 17};
            run_cycle(1'b0, b, ep, 2'b00);
        end

        // Both channels pending, one-cycle reset wipes them; next tick 8 cycles after release.
        cur_test = "mid_rst";
        do_reset();
        for (int k = 1; k <= 6; k++) begin
            b  = (k == 2 || k == 3) ? 2'b00 : 2'b11;
            en = (k >= 5) ? 2'b11 : 2'b00;
            run_cycle(1'b0, b, 2'b00, en);
        end
        run_cycle(1'b1, 2'b11, 2'b00, 2'b00);
        for (int k = 1; k <= 20; k++) run_cycle(1'b0, 2'b11, 2'b00, 2'b00);
`else
        // 2-cycle glitch is filtered; a held press before edge 9 reaches pending at 16, pulse at 17.
        cur_test = "debounce";
        do_reset();
        for (int k = 1; k <= 26; k++) begin
            b  = {1'b1, (k == 2 || k == 3 || k >= 9) ? 1'b0 : 1'b1};
            ep = {1'b0, k == 17};
            en = {1'b0, k == 16};
            run_cycle(1'b0, b, ep, en);
        end
`endif

        repeat (3) @(negedge clk_50M);
        #1;
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
